// File: rtl/fetch_mem_unit.sv
// PC/IR/MDR owner bridging the multicycle controller to a req/ready memory.
// Optional wait-cycle abort with sticky mem_err when MEM_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module fetch_mem_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_write,
    input  logic        pc_write_cond,
    input  logic        zero,
    input  logic [1:0]  pc_source,
    input  logic [31:0] alu_result,
    input  logic [31:0] alu_out,
    input  logic        iord,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        ir_write,
    input  logic [31:0] wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] pc,
    output logic [31:0] instr_out,
    output logic [31:0] mdr,
    output logic        busy,
    output logic        mem_err
);
    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

    state_t      state, state_next;
    logic        ir_flag;
    logic        pc_load;
    logic [31:0] pc_next;
    logic        accept_rd, accept_wr, rd_done, timeout_hit;

    // The wait counter is 8 bits wide, so the limit must fit in it.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    always_comb begin
        pc_load = pc_write | (pc_write_cond & zero);
        pc_next = pc;
        case (pc_source)
            2'b00:   pc_next = alu_result;
            2'b01:   pc_next = alu_out;
            2'b10:   pc_next = {pc[31:26], instr_out[25:0]};
            default: pc_next = pc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (pc_load) begin
            pc <= pc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept_rd  = 1'b0;
        accept_wr  = 1'b0;
        rd_done    = 1'b0;
        case (state)
            IDLE: begin
                if (mem_read) begin
                    accept_rd  = 1'b1;
                    state_next = RD_WAIT;
                end else if (mem_write) begin
                    accept_wr  = 1'b1;
                    state_next = WR_WAIT;
                end
            end
            RD_WAIT, WR_WAIT: begin
                if (mem_ready) begin
                    rd_done    = (state == RD_WAIT);
                    state_next = IDLE;
                end else if (timeout_hit) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            ir_flag   <= 1'b0;
            mdr       <= '0;
            instr_out <= '0;
        end else begin
            if (accept_rd || accept_wr) begin
                mem_addr <= iord ? alu_out : pc;
                mem_we   <= accept_wr;
            end
            if (accept_rd) begin
                ir_flag <= ir_write;
            end
            if (accept_wr) begin
                mem_wdata <= wdata;
            end
            if (rd_done) begin
                mdr <= mem_rdata;
                if (ir_flag) begin
                    instr_out <= mem_rdata;
                end
            end
        end
    end

    assign mem_req = (state != IDLE);
    assign busy    = (state != IDLE);

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] wait_cnt;
    logic       err_q;

    // The abort edge is the one on which the counter would reach the limit.
    assign timeout_hit = (wait_cnt == TIMEOUT_LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else if (accept_rd || accept_wr) begin
            wait_cnt <= '0;
        end else if (state != IDLE && !mem_ready) begin
            if (timeout_hit) begin
                err_q <= 1'b1;
            end else begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

    assign mem_err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign mem_err     = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_mem_unit.sv
// Self-checking bench for fetch_mem_unit: PC vector table, memory transactions and random mix.
`timescale 1ns/1ps
module tb_fetch_mem_unit;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef MEM_TIMEOUT_EN
    localparam int unsigned TO = 4;
`else
    localparam int unsigned TO = 16;
`endif

    logic        clk, reset;
    logic        pc_write, pc_write_cond, zero;
    logic [1:0]  pc_source;
    logic [31:0] alu_result, alu_out, wdata, mem_rdata;
    logic        iord, mem_read, mem_write, ir_write, mem_ready;
    logic        mem_req, mem_we, busy, mem_err;
    logic [31:0] mem_addr, mem_wdata, pc, instr_out, mdr;

    fetch_mem_unit #(.RESET_PC(RST_PC), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .zero(zero), .pc_source(pc_source), .alu_result(alu_result), .alu_out(alu_out),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .wdata(wdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc(pc),
        .instr_out(instr_out), .mdr(mdr), .busy(busy), .mem_err(mem_err)
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [31:0] pc_m, ir_m, mdr_m, wd_m;

    typedef struct {
        logic        pw, pwc, z;
        logic [1:0]  src;
        logic [31:0] ar, ao, exp_pc;
    } pc_vec_t;
    pc_vec_t tbl [8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] pc_after(input logic [31:0] cur, ir, input logic pw, pwc, z,
                                             input logic [1:0] src, input logic [31:0] ar, ao);
        if (!(pw || (pwc && z))) return cur;
        case (src)
            2'd0:    return ar;
            2'd1:    return ao;
            2'd2:    return {cur[31:26], ir[25:0]};
            default: return cur;
        endcase
    endfunction

    task automatic check_reset_state(input string nm);
        chk({nm, " pc"}, pc, RST_PC);
        chk({nm, " instr"}, instr_out, 32'h0);
        chk({nm, " mdr"}, mdr, 32'h0);
        chk({nm, " req"}, {31'b0, mem_req}, 32'h0);
        chk({nm, " we"}, {31'b0, mem_we}, 32'h0);
        chk({nm, " addr"}, mem_addr, 32'h0);
        chk({nm, " wdata"}, mem_wdata, 32'h0);
        chk({nm, " busy"}, {31'b0, busy}, 32'h0);
        chk({nm, " err"}, {31'b0, mem_err}, 32'h0);
    endtask

    // Issues one command, plays memory with `lat` wait cycles, checks the whole transaction.
    task automatic txn(input string nm, input logic rd, input logic wr, input logic irw,
                       input logic io, input int unsigned lat, input logic [31:0] rdat,
                       input logic poke);
        logic [31:0] eaddr;
        logic        ewe;
        int unsigned reqc, bad;
        eaddr = io ? alu_out : pc_m;
        ewe   = !rd;
        if (!rd) wd_m = wdata;
        mem_read  = rd;
        mem_write = wr;
        ir_write  = irw;
        iord      = io;
        mem_ready = (lat == 0);
        mem_rdata = 32'hBAD0_0000;
        tick();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        ir_write  = !irw;
        iord      = !io;
        reqc = 0;
        bad  = 0;
        while (mem_req === 1'b1 && reqc < 64) begin
            if (mem_addr !== eaddr || mem_we !== ewe || mem_wdata !== wd_m || busy !== 1'b1) bad++;
            mem_ready = (reqc == lat);
            mem_rdata = (reqc == lat) ? rdat : ~rdat;
            if (poke && reqc == 0) begin
                mem_write = 1'b1;
                alu_out   = ~alu_out;
            end else begin
                mem_write = 1'b0;
            end
            reqc++;
            tick();
        end
        mem_ready = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        chk({nm, " req cycles"}, reqc, lat + 1);
        chk({nm, " unstable req cycles"}, bad, 32'h0);
        chk({nm, " busy after"}, {31'b0, busy}, 32'h0);
        if (rd) begin
            mdr_m = rdat;
            if (irw) ir_m = rdat;
        end
        chk({nm, " mdr"}, mdr, mdr_m);
        chk({nm, " instr"}, instr_out, ir_m);
        if (poke) begin
            for (int k = 0; k < 3; k++) begin
                tick();
                chk({nm, " no second req"}, {31'b0, mem_req}, 32'h0);
            end
        end
    endtask

    initial begin
        int unsigned reqc;
        reset = 1'b1;
        pc_write = 1'b0; pc_write_cond = 1'b0; zero = 1'b0; pc_source = 2'b00;
        alu_result = '0; alu_out = '0; wdata = '0; mem_rdata = '0;
        iord = 1'b0; mem_read = 1'b0; mem_write = 1'b0; ir_write = 1'b0; mem_ready = 1'b0;
        pc_m = RST_PC; ir_m = '0; mdr_m = '0; wd_m = '0;
        tick();
        tick();
        check_reset_state("reset");
        reset = 1'b0;

        txn("fetch", 1'b1, 1'b0, 1'b1, 1'b0, 3, 32'h4423_0001, 1'b0);
        alu_out = 32'h40;
        txn("load0", 1'b1, 1'b0, 1'b0, 1'b1, 0, 32'hDEAD_BEEF, 1'b0);
        alu_out = 32'h80; wdata = 32'h1234_5678;
        txn("store", 1'b0, 1'b1, 1'b0, 1'b1, 2, 32'h0, 1'b0);
        alu_out = 32'h44; wdata = 32'h5555_AAAA;
        txn("rd+wr", 1'b1, 1'b1, 1'b1, 1'b0, 1, 32'h0000_0123, 1'b0);

        tbl[0] = '{1'b1, 1'b0, 1'b0, 2'd0, 32'h0400_0010, 32'h0,  32'h0400_0010};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 2'd2, 32'h0,         32'h0,  32'h0400_0123};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 2'd1, 32'h0,         32'h20, 32'h0400_0123};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 2'd1, 32'h0,         32'h20, 32'h0000_0020};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 2'd3, 32'h77,        32'h88, 32'h0000_0020};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 2'd0, 32'h999,       32'h0,  32'h0000_0020};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 2'd0, 32'h44,        32'h0,  32'h0000_0044};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 2'd2, 32'h0,         32'h0,  32'h0000_0123};
        for (int i = 0; i < 8; i++) begin
            pc_write = tbl[i].pw; pc_write_cond = tbl[i].pwc; zero = tbl[i].z;
            pc_source = tbl[i].src; alu_result = tbl[i].ar; alu_out = tbl[i].ao;
            tick();
            pc_m = tbl[i].exp_pc;
            chk($sformatf("pc vec %0d", i), pc, pc_m);
        end
        pc_write = 1'b0; pc_write_cond = 1'b0;

        alu_out = 32'h0000_0300;
        txn("busy poke", 1'b1, 1'b0, 1'b0, 1'b1, 2, 32'hCAFE_0001, 1'b1);

        alu_out = 32'h0000_0500;
        mem_read = 1'b1; ir_write = 1'b1; iord = 1'b1;
        tick();
        mem_read = 1'b0; ir_write = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hFEED_FACE;
        tick();
        mem_ready = 1'b0;
        pc_m = RST_PC; ir_m = '0; mdr_m = '0; wd_m = '0;
        check_reset_state("mid-txn reset");

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                pc_write = 1'($urandom); pc_write_cond = 1'($urandom); zero = 1'($urandom);
                pc_source = 2'($urandom); alu_result = $urandom; alu_out = $urandom;
                tick();
                pc_m = pc_after(pc_m, ir_m, pc_write, pc_write_cond, zero, pc_source, alu_result, alu_out);
                chk("rand pc", pc, pc_m);
                pc_write = 1'b0; pc_write_cond = 1'b0;
            end else begin
                int unsigned cmd;
                cmd = $urandom_range(0, 2);
                alu_out = $urandom; wdata = $urandom;
                txn("rand txn", cmd != 1, cmd != 0, 1'($urandom), 1'($urandom),
                    $urandom_range(0, 3), $urandom, 1'b0);
            end
        end

`ifdef MEM_TIMEOUT_EN
        mem_read = 1'b1; ir_write = 1'b1; iord = 1'b0;
        tick();
        mem_read = 1'b0; ir_write = 1'b0;
        reqc = 0;
        while (mem_req === 1'b1 && reqc < 64) begin
            reqc++;
            tick();
        end
        chk("timeout req cycles", reqc, TO);
        chk("timeout err", {31'b0, mem_err}, 32'h1);
        chk("timeout busy", {31'b0, busy}, 32'h0);
        chk("timeout instr", instr_out, ir_m);
        chk("timeout mdr", mdr, mdr_m);
        repeat (3) tick();
        chk("timeout err sticky", {31'b0, mem_err}, 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        pc_m = RST_PC; ir_m = '0; mdr_m = '0; wd_m = '0;
        check_reset_state("reset after timeout");
`else
        reqc = 0;
        alu_out = 32'h0000_0600;
        txn("long wait", 1'b1, 1'b0, 1'b1, 1'b1, 20, 32'h0BAD_F00D, 1'b0);
        chk("long wait err", {31'b0, mem_err}, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_mem_unit.md
Name: fetch_mem_unit

Overview:
- Sits between the multicycle controller and instruction/data memory.
- Owns the PC, instruction register (IR) and memory data register (MDR).
- Executes the controller's PCWrite/PCWriteCond/PCSource, IorD, MemRead/MemWrite and IRWrite strobes against a variable-latency memory with a req/ready handshake.
- Feeds instr_out to the controller's instruction input and exports busy so the controller can stall.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT_CYCLES, 16, wait-cycle limit before abort (used only with the optional feature).

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- pc_write  in  1  unconditional PC load
- pc_write_cond  in  1  PC load if zero is high
- zero  in  1  ALU zero flag
- pc_source  in  2  00 alu_result, 01 alu_out, 10 jump target, 11 hold
- alu_result  in  32  combinational ALU output (PC+1 path)
- alu_out  in  32  registered ALU output (branch target / data address)
- iord  in  1  0 address = PC, 1 address = alu_out
- mem_read  in  1  start read command
- mem_write  in  1  start write command
- ir_write  in  1  read data also goes to IR
- wdata  in  32  store data (register B)
- mem_req  out  1  memory request valid
- mem_we  out  1  request is a write
- mem_addr  out  32  request address
- mem_wdata  out  32  request store data
- mem_rdata  in  32  memory read data, valid with mem_ready
- mem_ready  in  1  memory completes current request
- pc  out  32  program counter
- instr_out  out  32  IR contents
- mdr  out  32  MDR contents
- busy  out  1  memory transaction in progress
- mem_err  out  1  sticky timeout flag (tied 0 without the optional feature)

Behaviour:
- Reset, at any time including mid-transaction:
  - pc=RESET_PC; instr_out=0, mdr=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, mem_err=0.
  - FSM goes to IDLE. Any outstanding request is abandoned; a mem_ready arriving after reset is ignored.
- PC update, evaluated every cycle and independent of the memory FSM:
  - Load when pc_write | (pc_write_cond & zero).
  - Source values:
    - 00 alu_result
    - 01 alu_out
    - 10 {pc[31:26], instr_out[25:0]}
    - 11 pc unchanged
  - New value is visible the cycle after the strobe. No load means pc holds.
- FSM has three states: IDLE, RD_WAIT, WR_WAIT.
- IDLE accepting a command:
  - mem_read=1: latch addr=(iord ? alu_out : pc), we=0 and the ir_write flag; go to RD_WAIT.
  - mem_write=1 and mem_read=0: latch addr, we=1 and wdata; go to WR_WAIT.
  - mem_read and mem_write both high: the read wins and the write is dropped.
- Timing of an accepted command:
  - mem_req and busy rise the cycle after acceptance.
  - mem_addr, mem_we and mem_wdata are stable while mem_req=1.
- RD_WAIT / WR_WAIT:
  - mem_req held high until mem_ready is sampled high.
  - On that edge the FSM returns to IDLE, and mem_req and busy fall the next cycle.
- On read completion:
  - mdr<=mem_rdata.
  - instr_out<=mem_rdata only if the latched ir_write flag was 1.
  - The ir_write input level at completion time is irrelevant.
- Latency:
  - Minimum command-to-data is 2 edges (mem_ready high in the first req cycle).
  - Data is visible on instr_out/mdr the cycle busy falls.
- Commands while busy=1 are ignored, with no queueing; the controller must hold or reissue after busy falls.
- A new command may be accepted the cycle busy is low again.
- mem_ready while in IDLE is ignored.
- Without mem_ready, the FSM waits indefinitely.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - An 8-bit wait counter clears on command acceptance and increments each RD_WAIT/WR_WAIT cycle without mem_ready.
  - When the count reaches TIMEOUT_CYCLES, the transaction aborts: mem_req drops, the FSM goes to IDLE, and instr_out/mdr are unchanged.
  - mem_err sets and stays set until reset.
- Not defined: no counter; mem_err is constant 0; waits are unbounded.

Test Plan:
- Reset then fetch: mem_read=1, ir_write=1, iord=0; memory answers 32'h4423_0001 after 3 wait cycles -> mem_addr=0, mem_req high exactly 4 cycles, instr_out=mdr=32'h4423_0001, busy low after.
- Zero-wait load: iord=1, alu_out=32'h40, mem_ready tied high, rdata 32'hDEAD_BEEF -> mem_req for 1 cycle, mdr=32'hDEAD_BEEF, instr_out unchanged.
- Store: mem_write=1, wdata=32'h1234_5678, alu_out=32'h80, iord=1, ready after 2 cycles -> mem_we=1, mem_addr=32'h80, mem_wdata=32'h1234_5678 stable throughout; mdr unchanged.
- PC paths: pc=32'h0400_0010, IR=32'h0000_0123, pc_source=10, pc_write=1 -> pc=32'h0400_0123; pc_write_cond=1, zero=0 -> pc holds; zero=1, alu_out=32'h20 -> pc=32'h20.
- Boundary: read issued, reset asserted during wait, stale mem_ready the next cycle -> all outputs at reset values, instr_out stays 0; mem_write pulsed while busy -> no second request.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, mem_ready never asserted -> mem_req drops after 4 wait cycles, mem_err=1 until reset, busy low, instr_out unchanged.
